// File: rtl/fir_sym_mc.sv
// Multi-channel symmetric FIR: one folded tap pair per MAC cycle, shared
// external coefficient memory, per-channel circular delay lines.
module fir_sym_mc #(
   parameter int NrOfTaps        = 10,
   parameter int NrOfChannels    = 2,
   parameter int NrOfBanks       = 2,
   parameter int SampleWidth     = 8,
   parameter int CoeffWidth      = 12,
   parameter int OutWidth        = 8,
   parameter int ShiftLSBs       = 11,
   parameter int AccWidth        = 24,
   parameter int CoeffAddrsWidth = 4,
   parameter int ChanWidth       = 1,
   parameter int BankWidth       = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          sampleValid,
   output logic                          sampleReady,
   input  logic signed [SampleWidth-1:0] sample,
   input  logic [ChanWidth-1:0]          sampleChan,
   input  logic [BankWidth-1:0]          coeffBank,
   output logic                          read,
   output logic [CoeffAddrsWidth-1:0]    coeffAddrs,
   input  logic signed [CoeffWidth-1:0]  coeff,
   output logic signed [OutWidth-1:0]    sum,
   output logic [ChanWidth-1:0]          sumChan,
   output logic                          dav,
   output logic                          sat
);

   localparam int H       = (NrOfTaps + 1) / 2;
   localparam int Depth   = NrOfTaps - 1;
   localparam int PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int StepW   = (H > 1) ? $clog2(H) : 1;
   localparam int PreW    = SampleWidth + 1;
   localparam int ProdW   = SampleWidth + CoeffWidth + 1;
   localparam bit OddTaps = (NrOfTaps % 2) == 1;
   localparam int RoundBit = (ShiftLSBs > 0) ? ShiftLSBs - 1 : 0;
   localparam logic signed [AccWidth-1:0] RoundConst =
      (ShiftLSBs > 0) ? AccWidth'(longint'(1) << RoundBit) : '0;
   localparam longint MaxOutL = (longint'(1) << (OutWidth - 1)) - 1;
   localparam logic signed [AccWidth-1:0] MaxOut = AccWidth'(MaxOutL);
   localparam logic signed [AccWidth-1:0] MinOut = AccWidth'(-MaxOutL - 1);

   typedef enum logic [1:0] {IDLE, PRIME, MAC, OUT} state_t;
   state_t state, nextState;

   logic                          readyReg;
   logic signed [SampleWidth-1:0] sampleReg;
   logic [ChanWidth-1:0]          chanReg;
   logic [BankWidth-1:0]          bankReg;
   logic                          discard;
   logic [StepW-1:0]              step;
   logic signed [AccWidth-1:0]    acc;
   logic signed [AccWidth-1:0]    rounded;
   logic signed [SampleWidth-1:0] hist [NrOfChannels][Depth];
   logic [PtrW-1:0]               wrPtr [NrOfChannels];
   logic signed [SampleWidth-1:0] chHist [Depth];
   logic [PtrW-1:0]               chPtr;
   logic signed [SampleWidth-1:0] tapA, tapB;
   logic signed [PreW-1:0]        pre;
   logic signed [ProdW-1:0]       prod;
   logic signed [AccWidth-1:0]    prodExt;

   // Round half up, then arithmetic shift down to the output scale.
   function automatic logic signed [AccWidth-1:0] roundShift(input logic signed [AccWidth-1:0] v);
      return (v + RoundConst) >>> ShiftLSBs;
   endfunction

   function automatic logic isSat(input logic signed [AccWidth-1:0] v);
      return (v > MaxOut) || (v < MinOut);
   endfunction

   function automatic logic signed [OutWidth-1:0] clip(input logic signed [AccWidth-1:0] v);
      if (v > MaxOut) return OutWidth'(MaxOut);
      if (v < MinOut) return OutWidth'(MinOut);
      return OutWidth'(v);
   endfunction

   assign sampleReady = readyReg;
   assign rounded     = roundShift(acc);

   // State register; ready is registered so it rises on the first edge after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         readyReg <= 1'b0;
      end else begin
         state    <= nextState;
         readyReg <= (nextState == IDLE);
      end
   end

   // Next-state logic and coefficient fetch, one address ahead of the MAC step.
   always_comb begin
      nextState  = state;
      read       = 1'b0;
      coeffAddrs = '0;
      case (state)
         IDLE:  if (sampleValid && readyReg) nextState = PRIME;
         PRIME: begin
            nextState = discard ? IDLE : MAC;
            if (!discard) begin
               read       = 1'b1;
               coeffAddrs = CoeffAddrsWidth'(int'(bankReg) * H);
            end
         end
         MAC: begin
            if (step == StepW'(H - 1)) nextState = OUT;
            else begin
               read       = 1'b1;
               coeffAddrs = CoeffAddrsWidth'(int'(bankReg) * H + int'(step) + 1);
            end
         end
         OUT:     nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Select the active channel's history and pointer.
   always_comb begin
      chPtr = '0;
      for (int d = 0; d < Depth; d++) chHist[d] = '0;
      for (int c = 0; c < NrOfChannels; c++) begin
         if (int'(chanReg) == c) begin
            chPtr = wrPtr[c];
            for (int d = 0; d < Depth; d++) chHist[d] = hist[c][d];
         end
      end
   end

   // Fetch x[n-i] and x[n-(N-1-i)], pre-add the pair (centre tap alone), multiply.
   always_comb begin
      int kA, kB, idxA, idxB;
      kA   = int'(step);
      kB   = NrOfTaps - 1 - kA;
      idxA = int'(chPtr) - kA;
      if (idxA < 0) idxA = idxA + Depth;
      idxB = int'(chPtr) - kB;
      if (idxB < 0) idxB = idxB + Depth;
      tapA = (kA == 0) ? sampleReg : chHist[PtrW'(idxA)];
      tapB = chHist[PtrW'(idxB)];
      if (OddTaps && (kA == H - 1)) pre = PreW'(tapA);
      else                          pre = PreW'(tapA) + PreW'(tapB);
      prod    = ProdW'(pre) * ProdW'(coeff);
      prodExt = AccWidth'(prod);
   end

   // Sample latch, accumulator and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sampleReg <= '0;
         chanReg   <= '0;
         bankReg   <= '0;
         discard   <= 1'b0;
         step      <= '0;
         acc       <= '0;
         sum       <= '0;
         sumChan   <= '0;
         dav       <= 1'b0;
         sat       <= 1'b0;
      end else begin
         dav <= 1'b0;
         sat <= 1'b0;
         case (state)
            IDLE: begin
               if (sampleValid && readyReg) begin
                  sampleReg <= sample;
                  chanReg   <= sampleChan;
                  bankReg   <= coeffBank;
                  discard   <= (int'(sampleChan) >= NrOfChannels);
               end
            end
            PRIME: begin
               acc  <= '0;
               step <= '0;
            end
            MAC: begin
               acc  <= acc + prodExt;
               step <= step + 1'b1;
            end
            OUT: begin
               sum     <= clip(rounded);
               sat     <= isSat(rounded);
               sumChan <= chanReg;
               dav     <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Delay lines change only in OUT, keeping history stable across the MAC steps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NrOfChannels; c++) begin
            wrPtr[c] <= '0;
            for (int d = 0; d < Depth; d++) hist[c][d] <= '0;
         end
      end else if (state == OUT) begin
         for (int c = 0; c < NrOfChannels; c++) begin
            if (int'(chanReg) == c) begin
               hist[c][wrPtr[c]] <= sampleReg;
               wrPtr[c] <= (wrPtr[c] == PtrW'(Depth - 1)) ? '0 : wrPtr[c] + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_sym_mc.sv
// Bench for fir_sym_mc: instance A (5 taps, 3 channels, no shift) and
// instance B (4 taps, 2 channels, shift 2), each with a coefficient ROM.
module tb_fir_sym_mc;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, got, want);
      end
   endtask

   // Instance A signals
   logic              aValid = 1'b0, aReady, aBank = 1'b0, aRead, aDav, aSat;
   logic signed [7:0] aSample = '0, aSum;
   logic [1:0]        aChan = '0, aSumChan;
   logic [3:0]        aAddr;
   logic signed [11:0] aCoeff = '0;
   // Instance B signals
   logic              bValid = 1'b0, bReady, bBank = 1'b0, bRead, bDav, bSat;
   logic signed [7:0] bSample = '0, bSum;
   logic              bChan = 1'b0, bSumChan;
   logic [3:0]        bAddr;
   logic signed [11:0] bCoeff = '0;

   int romA[6] = '{1, 2, 3, 0, 0, 1};
   int romB[4] = '{1, 2, -1, 3};

   always @(posedge clk) if (aRead && aAddr < 6) aCoeff <= 12'(romA[aAddr]);
   always @(posedge clk) if (bRead && bAddr < 4) bCoeff <= 12'(romB[bAddr]);

   fir_sym_mc #(.NrOfTaps(5), .NrOfChannels(3), .ShiftLSBs(0), .ChanWidth(2)) dutA (
      .clk(clk), .reset(reset), .sampleValid(aValid), .sampleReady(aReady),
      .sample(aSample), .sampleChan(aChan), .coeffBank(aBank), .read(aRead),
      .coeffAddrs(aAddr), .coeff(aCoeff), .sum(aSum), .sumChan(aSumChan),
      .dav(aDav), .sat(aSat));

   fir_sym_mc #(.NrOfTaps(4), .NrOfChannels(2), .ShiftLSBs(2), .ChanWidth(1)) dutB (
      .clk(clk), .reset(reset), .sampleValid(bValid), .sampleReady(bReady),
      .sample(bSample), .sampleChan(bChan), .coeffBank(bBank), .read(bRead),
      .coeffAddrs(bAddr), .coeff(bCoeff), .sum(bSum), .sumChan(bSumChan),
      .dav(bDav), .sat(bSat));

   // Reference model: direct-form convolution, newest sample at index 0.
   int histA[3][5];
   int histB[2][4];

   function automatic int refOut(input int raw, input int sh, output int sv);
      int r;
      r = raw;
      if (sh > 0) r = (raw + (1 << (sh - 1))) >>> sh;
      sv = 0;
      if (r > 127) begin r = 127; sv = 1; end
      else if (r < -128) begin r = -128; sv = 1; end
      return r;
   endfunction

   function automatic void modelA(input int chan, input int bank, input int x, output int s, output int sv);
      int raw;
      raw = 0;
      for (int k = 4; k > 0; k--) histA[chan][k] = histA[chan][k-1];
      histA[chan][0] = x;
      for (int k = 0; k < 5; k++) begin
         int t;
         t = (k <= 2) ? k : 4 - k;
         raw += histA[chan][k] * romA[bank*3 + t];
      end
      s = refOut(raw, 0, sv);
   endfunction

   function automatic void modelB(input int chan, input int bank, input int x, output int s, output int sv);
      int raw;
      raw = 0;
      for (int k = 3; k > 0; k--) histB[chan][k] = histB[chan][k-1];
      histB[chan][0] = x;
      for (int k = 0; k < 4; k++) begin
         int t;
         t = (k <= 1) ? k : 3 - k;
         raw += histB[chan][k] * romB[bank*2 + t];
      end
      s = refOut(raw, 2, sv);
   endfunction

   function automatic void clearModel();
      for (int c = 0; c < 3; c++) for (int k = 0; k < 5; k++) histA[c][k] = 0;
      for (int c = 0; c < 2; c++) for (int k = 0; k < 4; k++) histB[c][k] = 0;
   endfunction

   typedef struct {int cyc; int chan; int sum; int sat;} exp_t;
   exp_t qA[$];
   exp_t qB[$];
   int lastA = 0;
   int lastB = 0;

   always @(negedge clk) begin
      if (reset === 1'b0 && aDav === 1'b1) begin
         if (qA.size() == 0) chk("A_spurious_dav", 1, 0);
         else begin
            exp_t e;
            e = qA.pop_front();
            chk("A_sum", aSum, e.sum);
            chk("A_chan", aSumChan, e.chan);
            chk("A_sat", aSat, e.sat);
            chk("A_latency", cyc, e.cyc);
            chk("A_ready_at_dav", aReady, 1);
            lastA = e.sum;
         end
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b0 && bDav === 1'b1) begin
         if (qB.size() == 0) chk("B_spurious_dav", 1, 0);
         else begin
            exp_t e;
            e = qB.pop_front();
            chk("B_sum", bSum, e.sum);
            chk("B_chan", bSumChan, e.chan);
            chk("B_sat", bSat, e.sat);
            chk("B_latency", cyc, e.cyc);
            chk("B_ready_at_dav", bReady, 1);
            lastB = e.sum;
         end
      end
   end

   // Drive one sample, wait for acceptance, push the expected result.
   task automatic send(input int inst, input int chan, input int bank, input int x);
      int s, sv, n;
      exp_t e;
      @(negedge clk);
      if (inst == 0) begin
         aSample = 8'(x); aChan = 2'(chan); aBank = 1'(bank); aValid = 1'b1;
      end else begin
         bSample = 8'(x); bChan = 1'(chan); bBank = 1'(bank); bValid = 1'b1;
      end
      n = 0;
      while (((inst == 0) ? aReady : bReady) !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (n >= 60) begin
         if (inst == 0) chk("A_ready_timeout", 0, 1);
         else           chk("B_ready_timeout", 0, 1);
         aValid = 1'b0;
         bValid = 1'b0;
         return;
      end
      if (inst == 0 && chan < 3) begin
         modelA(chan, bank, x, s, sv);
         e = '{cyc + 6, chan, s, sv};
         qA.push_back(e);
      end else if (inst == 1) begin
         modelB(chan, bank, x, s, sv);
         e = '{cyc + 5, chan, s, sv};
         qB.push_back(e);
      end
      @(posedge clk);
      #1;
      aValid = 1'b0;
      bValid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((qA.size() != 0 || qB.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", qA.size() + qB.size(), 0);
      repeat (3) @(negedge clk);
      chk("A_sum_hold", aSum, lastA);
      chk("B_sum_hold", bSum, lastB);
      chk("A_sat_idle", aSat, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int imp[6] = '{10, 0, 0, 0, 0, 0};
      int bseq[13] = '{16, 0, 0, 0, 0, 6, 0, 0, 0, -6, 0, 0, 0};
      clearModel();
      repeat (3) @(negedge clk);
      chk("rst_A_ready", aReady, 0);
      chk("rst_B_ready", bReady, 0);
      chk("rst_A_dav", aDav, 0);
      chk("rst_A_sum", aSum, 0);
      chk("rst_A_sumchan", aSumChan, 0);
      chk("rst_A_sat", aSat, 0);
      chk("rst_A_read", aRead, 0);
      chk("rst_A_addr", aAddr, 0);
      reset = 1'b0;
      #1 chk("rel_A_ready_before_edge", aReady, 0);
      @(posedge clk);
      #1 chk("rel_A_ready_after_edge", aReady, 1);

      // Impulse on channel 0, bank 0
      for (int i = 0; i < 6; i++) send(0, 0, 0, imp[i]);
      drain();

      // Interleaved channels: ch0 impulse, ch1 constant 1
      for (int i = 0; i < 6; i++) begin
         send(0, 0, 0, imp[i]);
         send(0, 1, 0, 1);
      end
      drain();

      // Bank 1 impulse
      for (int i = 0; i < 5; i++) send(0, 0, 1, imp[i]);
      drain();

      // Saturation at both rails on channel 2
      repeat (5) send(0, 2, 0, 127);
      repeat (5) send(0, 2, 0, -128);
      repeat (4) send(0, 2, 0, 0);
      drain();

      // Out-of-range channel: accepted, dropped, back to ready after one cycle
      @(negedge clk);
      aSample = 8'sd55; aChan = 2'd3; aBank = 1'b0; aValid = 1'b1;
      chk("A_discard_ready_before", aReady, 1);
      @(posedge clk);
      #1 aValid = 1'b0;
      chk("A_discard_busy", aReady, 0);
      @(posedge clk);
      #1 chk("A_discard_ready", aReady, 1);
      repeat (10) @(negedge clk);

      // Even length with rounding on instance B
      for (int i = 0; i < 13; i++) send(1, 0, 0, bseq[i]);
      drain();

      // Reset during the second MAC cycle
      @(negedge clk);
      aSample = 8'sd50; aChan = 2'd0; aBank = 1'b0; aValid = 1'b1;
      @(posedge clk);
      #1 aValid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_A_dav", aDav, 0);
      chk("midrst_A_ready", aReady, 0);
      chk("midrst_A_read", aRead, 0);
      chk("midrst_A_addr", aAddr, 0);
      chk("midrst_A_sum", aSum, 0);
      clearModel();
      lastA = 0;
      lastB = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk("midrst_ready_before_edge", aReady, 0);
      @(posedge clk);
      #1 chk("midrst_ready_after_edge", aReady, 1);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 6; i++) send(0, 0, 0, imp[i]);
      drain();

      // Random traffic on both instances
      for (int i = 0; i < 30; i++) begin
         int inst, x;
         inst = int'($urandom_range(0, 1));
         x = int'($urandom_range(0, 255)) - 128;
         if (inst == 0) send(0, int'($urandom_range(0, 2)), int'($urandom_range(0, 1)), x);
         else           send(1, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), x);
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
